// File: rtl/mult_div_pkg.sv
// Shared encodings for the multiply/divide unit: mdu_op codes and FSM state codes.
package mult_div_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } mdu_state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mult_div_div_core.sv
// One restoring-division step on unsigned magnitudes: shift {rem,quo} left, trial-subtract divisor.
module div_core #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem,
  input  logic [DATA_W-1:0] quo,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_nxt,
  output logic [DATA_W-1:0] quo_nxt
);

  logic [DATA_W:0] trial;

  // rem < divisor always, so the shifted value fits DATA_W+1 bits and the MSB is the borrow
  assign trial = {rem, quo[DATA_W-1]} - {1'b0, divisor};

  always_comb begin
    rem_nxt = {rem[DATA_W-2:0], quo[DATA_W-1]};
    quo_nxt = {quo[DATA_W-2:0], 1'b0};
    if (!trial[DATA_W]) begin
      rem_nxt = trial[DATA_W-1:0];
      quo_nxt = {quo[DATA_W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mult_div.sv
// Iterative MULT/MULTU/DIV/DIVU unit, one radix-2 step per cycle on operand magnitudes.
// Define MDU_FAST_MULT_EN to complete multiplies in a single cycle with a combinational multiplier.
module mult_div
  import mult_div_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mdu_op,
  input  logic [DATA_W-1:0] operand_1,
  input  logic [DATA_W-1:0] operand_2,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CNT_W = $clog2(DATA_W);

  mdu_state_e        state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] opb_q, acc_hi, acc_lo;
  logic              div_q, neg_res, neg_rem;
  logic              in_div, in_sgn, a_neg, b_neg, div_zero, fast_mul, accept, last;
  logic [DATA_W-1:0] a_mag, b_mag;
  logic [DATA_W:0]   mul_sum;
  logic [DATA_W-1:0] div_rem, div_quo, step_hi, step_lo, res_hi, res_lo;
  logic [2*DATA_W-1:0] prod_fix;

  assign in_div   = op_is_div(mdu_op);
  assign in_sgn   = op_is_signed(mdu_op);
  assign a_neg    = in_sgn & operand_1[DATA_W-1];
  assign b_neg    = in_sgn & operand_2[DATA_W-1];
  assign a_mag    = a_neg ? -operand_1 : operand_1;
  assign b_mag    = b_neg ? -operand_2 : operand_2;
  assign div_zero = in_div && (operand_2 == '0);
  assign accept   = (state == S_IDLE) && start && !flush;
  assign last     = (cnt == CNT_W'(DATA_W - 1));

`ifdef MDU_FAST_MULT_EN
  logic [2*DATA_W-1:0] fast_prod, fast_fix;
  assign fast_mul  = !in_div;
  assign fast_prod = {{DATA_W{1'b0}}, a_mag} * {{DATA_W{1'b0}}, b_mag};
  assign fast_fix  = (a_neg ^ b_neg) ? -fast_prod : fast_prod;
`else
  assign fast_mul = 1'b0;
`endif

  // Multiply: acc_lo holds the shrinking multiplier; divide: acc_lo holds dividend bits turning into quotient
  assign mul_sum = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opb_q : '0)};

  div_core #(.DATA_W(DATA_W)) u_div_core (
    .rem     (acc_hi),
    .quo     (acc_lo),
    .divisor (opb_q),
    .rem_nxt (div_rem),
    .quo_nxt (div_quo)
  );

  always_comb begin
    step_hi  = div_q ? div_rem : mul_sum[DATA_W:1];
    step_lo  = div_q ? div_quo : {mul_sum[0], acc_lo[DATA_W-1:1]};
    prod_fix = neg_res ? -{step_hi, step_lo} : {step_hi, step_lo};
    res_hi   = prod_fix[2*DATA_W-1:DATA_W];
    res_lo   = prod_fix[DATA_W-1:0];
    if (div_q) begin
      res_hi = neg_rem ? -step_hi : step_hi;
      res_lo = neg_res ? -step_lo : step_lo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = (div_zero || fast_mul) ? S_DONE : S_CALC;
      S_CALC:  if (flush) state_nxt = S_IDLE;
               else if (last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      opb_q   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      div_q   <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else if (accept) begin
      cnt     <= '0;
      opb_q   <= b_mag;
      acc_hi  <= '0;
      acc_lo  <= a_mag;
      div_q   <= in_div;
      neg_res <= a_neg ^ b_neg;
      neg_rem <= a_neg;
      if (div_zero) begin
        hi <= operand_1;
        lo <= '1;
      end
`ifdef MDU_FAST_MULT_EN
      else if (fast_mul) begin
        hi <= fast_fix[2*DATA_W-1:DATA_W];
        lo <= fast_fix[DATA_W-1:0];
      end
`endif
    end else if (state == S_CALC && !flush) begin
      acc_hi <= step_hi;
      acc_lo <= step_lo;
      cnt    <= cnt + CNT_W'(1);
      if (last) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
  end

  assign busy = (state == S_CALC);
  // A flush landing in the DONE cycle cancels the pulse seen by EX
  assign done = (state == S_DONE) && !flush;

endmodule

// File: tb/tb_mult_div.sv
// Scoreboard bench for mult_div: expected {hi,lo} queued at launch, popped when done fires.
module tb_mult_div;
  localparam int DW = 32;
  // Latency counted as posedges after the accepting edge until done is visible
  localparam int LAT_ITER = 32;
`ifdef MDU_FAST_MULT_EN
  localparam int LAT_MUL = 0;
`else
  localparam int LAT_MUL = 32;
`endif

  logic          clk = 1'b0;
  logic          rst_n, start, flush;
  logic [1:0]    mdu_op;
  logic [DW-1:0] operand_1, operand_2;
  logic          busy, done;
  logic [DW-1:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [2*DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  mult_div #(.DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mdu_op    (mdu_op),
    .operand_1 (operand_1),
    .operand_2 (operand_2),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  function automatic logic [63:0] ref_mdu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    int sa, sb;
    logic [31:0] q, r;
    case (op)
      2'b00: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return sp;
      end
      2'b01: return {32'b0, a} * {32'b0, b};
      2'b11: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sa = $signed(a);
        sb = $signed(b);
        q = 32'(sa / sb);
        r = 32'(sa % sb);
        return {r, q};
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
    if (op[1] && b == 0) return 0;
    if (op[1]) return LAT_ITER;
    return LAT_MUL;
  endfunction

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] ohi, output logic [31:0] olo, output int lat,
                       output logic got, output logic busy_first, output logic busy_done);
    exp_q.push_back(ref_mdu(op, a, b));
    @(negedge clk);
    start = 1'b1; mdu_op = op; operand_1 = a; operand_2 = b;
    @(posedge clk); #1;
    start = 1'b0; operand_1 = $urandom; operand_2 = $urandom; mdu_op = 2'($urandom);
    got = 1'b0; lat = 0; busy_first = 1'b0; busy_done = 1'b0; ohi = '0; olo = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i == 0) busy_first = busy;
      if (done) begin
        got = 1'b1; ohi = hi; olo = lo; busy_done = busy;
        break;
      end
      lat++;
    end
  endtask

  task automatic test_arith(input string nm, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] h, l;
    int lat, elat;
    logic got, bf, bd;
    logic [63:0] e;
    elat = exp_lat(op, b);
    do_op(op, a, b, h, l, lat, got, bf, bd);
    e = exp_q.pop_front();
    checks++;
    if (!got || {h, l} !== e) begin
      errors++;
      $display("FAIL %s result: got done=%0b hi_lo=%h expected %h", nm, got, {h, l}, e);
    end
    checks++;
    if (lat != elat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", nm, lat, elat);
    end
    checks++;
    if (bf !== (elat != 0)) begin
      errors++;
      $display("FAIL %s busy_after_start: got %0b expected %0b", nm, bf, (elat != 0));
    end
    checks++;
    if (got && bd !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_in_done: got %0b expected 0", nm, bd);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse_width: done still %0b expected 0", nm, done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0; flush = 1'b0; mdu_op = 2'b00; operand_1 = '0; operand_2 = '0;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({busy, done, hi, lo} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%0b done=%0b hi=%h lo=%h expected all 0", busy, done, hi, lo);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle: got busy=%0b done=%0b expected 0 0", busy, done);
    end
  endtask

  task automatic test_spec_vectors();
    test_arith("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++;
    if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
      errors++;
      $display("FAIL multu_max_const: got %h_%h expected fffffffe_00000001", hi, lo);
    end
    test_arith("mult_neg3x7", 2'b00, 32'hFFFF_FFFD, 32'd7);
    checks++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      errors++;
      $display("FAIL mult_neg3x7_const: got %h_%h expected ffffffff_ffffffeb", hi, lo);
    end
    test_arith("div_neg7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
    checks++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      errors++;
      $display("FAIL div_neg7_2_const: got %h_%h expected ffffffff_fffffffd", hi, lo);
    end
    test_arith("divu_by_zero", 2'b11, 32'd100, 32'd0);
    checks++;
    if ({hi, lo} !== {32'd100, 32'hFFFF_FFFF}) begin
      errors++;
      $display("FAIL divu_by_zero_const: got %h_%h expected 00000064_ffffffff", hi, lo);
    end
    test_arith("div_by_zero_signed", 2'b10, 32'hFFFF_FF00, 32'd0);
    test_arith("div_overflow", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    checks++;
    if ({hi, lo} !== {32'h0, 32'h8000_0000}) begin
      errors++;
      $display("FAIL div_overflow_const: got %h_%h expected 00000000_80000000", hi, lo);
    end
    test_arith("div_pos_neg", 2'b10, 32'd17, 32'hFFFF_FFFB);
    test_arith("mult_neg_neg", 2'b00, 32'h8000_0000, 32'h8000_0000);
  endtask

  task automatic test_ignore_start();
    logic [63:0] e;
    int lat, extra;
    logic got;
    exp_q.push_back(ref_mdu(2'b11, 32'd10, 32'd3));
    @(negedge clk);
    start = 1'b1; mdu_op = 2'b11; operand_1 = 32'd10; operand_2 = 32'd3;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; mdu_op = 2'b01; operand_1 = 32'd7; operand_2 = 32'd9;
    @(posedge clk); #1 start = 1'b0;
    lat = 5; got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
      lat++;
    end
    e = exp_q.pop_front();
    checks++;
    if (!got || {hi, lo} !== e || {hi, lo} !== {32'd1, 32'd3}) begin
      errors++;
      $display("FAIL ignore_start_result: got done=%0b %h_%h expected %h", got, hi, lo, e);
    end
    checks++;
    if (lat != LAT_ITER) begin
      errors++;
      $display("FAIL ignore_start_latency: got %0d expected %0d", lat, LAT_ITER);
    end
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL ignore_start_no_launch: got %0d busy/done cycles expected 0", extra);
    end
  endtask

  task automatic test_flush();
    int seen;
    test_arith("prior_multu", 2'b01, 32'd5, 32'd6);
    @(negedge clk);
    start = 1'b1; mdu_op = 2'b11; operand_1 = 32'd1000; operand_2 = 32'd7;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_busy: got %0b expected 0", busy);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL flush_no_done: got %0d done pulses expected 0", seen);
    end
    checks++;
    if ({hi, lo} !== {32'd0, 32'd30}) begin
      errors++;
      $display("FAIL flush_hold: got %h_%h expected 00000000_0000001e", hi, lo);
    end
    @(negedge clk);
    start = 1'b1; flush = 1'b1; mdu_op = 2'b11; operand_1 = 32'd9; operand_2 = 32'd0;
    @(posedge clk); #1 start = 1'b0; flush = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    checks++;
    if (seen != 0 || {hi, lo} !== {32'd0, 32'd30}) begin
      errors++;
      $display("FAIL flush_start_same_edge: got %0d active cycles hi_lo=%h_%h expected 0 and 00000000_0000001e", seen, hi, lo);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1; mdu_op = 2'b11; operand_1 = 32'd1000; operand_2 = 32'd7;
    @(posedge clk); #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_busy_before: got %0b expected 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, hi, lo} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got busy=%0b done=%0b hi=%h lo=%h expected all 0", busy, done, hi, lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_arith("after_reset_div", 2'b10, 32'hFFFF_FFF9, 32'd2);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [1:0] op;
    for (int i = 0; i < 8; i++) begin
      op = 2'(i);
      a = $urandom;
      b = (i == 6) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      test_arith($sformatf("random_%0d", i), op, a, b);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_spec_vectors();
    test_ignore_start();
    test_flush();
    test_reset_mid();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div.md
MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 Parameter: DATA_W, 32, operand and result width.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 Port: start  input  1  launch request from EX, sampled at clk rise.
REQ-005 Port: mdu_op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 Port: operand_1  input  DATA_W  multiplicand/dividend, from ID operand_1 path.
REQ-007 Port: operand_2  input  DATA_W  multiplier/divisor, from ID operand_2 path.
REQ-008 Port: flush  input  1  cancel in-flight operation (exception/branch kill).
REQ-009 Port: busy  output  1  pipeline stall request while an operation is in flight.
REQ-010 Port: done  output  1  one-cycle pulse, hi/lo valid.
REQ-011 Port: hi  output  DATA_W  product[63:32] or remainder.
REQ-012 Port: lo  output  DATA_W  product[31:0] or quotient.

Function
REQ-013 FSM states IDLE, CALC, DONE; start accepted only in IDLE; start in CALC or DONE ignored.
REQ-014 Operands and mdu_op latched on the accepting edge; later input changes have no effect.
REQ-015 IDLE+start -> CALC, counter=0; CALC performs one radix-2 iteration per cycle; 32nd iteration -> DONE; DONE -> IDLE unconditionally.
REQ-016 Iterative latency: start at edge k -> done high in cycle k+33; busy high cycles k+1..k+32, low in DONE cycle.
REQ-017 MULTU: 64-bit unsigned shift-add product; MULT: multiply magnitudes, negate 64-bit product if operand sign bits differ.
REQ-018 DIVU: restoring division, lo=quotient, hi=remainder; DIV: magnitude divide, quotient negated if signs differ, remainder takes dividend sign.
REQ-019 Divide-by-zero: skip CALC, IDLE -> DONE; lo=32'hFFFFFFFF, hi=operand_1.
REQ-020 DIV 32'h80000000 / 32'hFFFFFFFF: lo=32'h80000000, hi=0, normal latency.
REQ-021 hi/lo update only on entering DONE; held until next DONE.
REQ-022 flush in CALC or DONE -> IDLE next edge, done suppressed, hi/lo unchanged.
REQ-023 flush and start same edge in IDLE: flush wins, nothing accepted.

Reset
REQ-024 rst_n low: state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0, immediately and asynchronously.
REQ-025 Reset mid-operation abandons it; first accepted start after rst_n release behaves normally.

Configuration
REQ-026 Macro MDU_FAST_MULT_EN defined: MULT/MULTU use a combinational 32x32 multiplier, IDLE -> DONE, done in cycle k+1, busy never asserted for multiplies.
REQ-027 Macro undefined: multiplies use the iterative path of REQ-016; division identical either way.

Structure
REQ-028 mdu_op encodings and FSM state codes belong in shared header (bus.v/funct.v group), not local defines.
REQ-029 One sub-module, div_core: iterative unsigned remainder/quotient step logic; sign fix-up and FSM stay in mult_div.

Verification
REQ-030 MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001, done at k+33 (k+1 with MDU_FAST_MULT_EN).
REQ-031 MULT -3 x 7 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
REQ-032 DIV -7 / 2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIVU 100 / 0 -> lo=32'hFFFFFFFF, hi=100 one cycle after start.
REQ-033 DIVU 10/3 started, second start at cycle k+5 ignored -> lo=3, hi=1 at k+33.
REQ-034 flush at k+10 -> busy low from k+11, no done, hi/lo keep prior values; rst_n low at k+20 of new op -> all outputs 0 immediately.
